uart_alu_wrap: RTL and testbench

//  UART-attached packet engine; top-level datapath of the FPGA build (the board top adds only the PLL).

---
 rtl/uart_alu_wrap.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_alu_wrap.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_wrap.sv
// uart_alu_wrap: UART packet engine answering echo / add32 / mul32 commands.
// 8N1 serial in and out, byte FIFO between the command parser and the transmitter.

module uart_rx #(
   parameter logic [15:0] Prescale = 16'd27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] tdata,
   output logic       tvalid,
   input  logic       tready
);
   localparam logic [18:0] BitLen  = {Prescale, 3'b000};
   localparam logic [18:0] HalfLen = {1'b0, Prescale, 2'b00};

   logic [1:0]  sync;
   logic        busy;
   logic [18:0] tmr;
   logic [3:0]  idx;
   logic [7:0]  sh;

   // bit timer samples start/data/stop near bit centre; bad stop drops the byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync   <= 2'b11;
         busy   <= 1'b0;
         tmr    <= '0;
         idx    <= '0;
         sh     <= '0;
         tdata  <= '0;
         tvalid <= 1'b0;
      end else begin
         sync <= {sync[0], rxd};
         if (tvalid && tready) tvalid <= 1'b0;
         if (!busy) begin
            if (!sync[1]) begin
               busy <= 1'b1;
               tmr  <= HalfLen - 19'd1;
               idx  <= '0;
            end
         end else if (tmr != '0) begin
            tmr <= tmr - 19'd1;
         end else begin
            tmr <= BitLen - 19'd1;
            if (idx == 4'd0) begin
               if (sync[1]) busy <= 1'b0;
               else idx <= 4'd1;
            end else if (idx != 4'd9) begin
               sh  <= {sync[1], sh[7:1]};
               idx <= idx + 4'd1;
            end else begin
               busy <= 1'b0;
               if (sync[1] && (!tvalid || tready)) begin
                  tvalid <= 1'b1;
                  tdata  <= sh;
               end
            end
         end
      end
   end
endmodule

module uart_tx #(
   parameter logic [15:0] Prescale = 16'd27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tdata,
   input  logic       tvalid,
   output logic       tready,
   output logic       txd
);
   localparam logic [18:0] BitLen = {Prescale, 3'b000};

   logic        busy;
   logic [18:0] tmr;
   logic [3:0]  idx;
   logic [8:0]  sh;

   assign tready = !busy;

   // shift out start bit, 8 data bits LSB first, then stop bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         tmr  <= '0;
         idx  <= '0;
         sh   <= '1;
         txd  <= 1'b1;
      end else if (!busy) begin
         if (tvalid) begin
            busy <= 1'b1;
            txd  <= 1'b0;
            sh   <= {1'b1, tdata};
            idx  <= '0;
            tmr  <= BitLen - 19'd1;
         end
      end else if (tmr != '0) begin
         tmr <= tmr - 19'd1;
      end else if (idx != 4'd9) begin
         txd <= sh[0];
         sh  <= {1'b1, sh[8:1]};
         idx <= idx + 4'd1;
         tmr <= BitLen - 19'd1;
      end else begin
         busy <= 1'b0;
      end
   end
endmodule

module uart_alu_wrap #(
   parameter logic [15:0] Prescale = 16'd27
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic rx_data_i,
   output logic tx_data_o
);
   typedef enum logic [2:0] {HDR0, HDR1, LENL, LENH, PAYLOAD, RESP} state_t;

   state_t      state, nxt;
   logic [7:0]  rx_byte, op, len_lo, push_data;
   logic        rx_valid, rx_ready, take, push, arith, last;
   logic [15:0] plen, pcnt, len_full;
   logic [31:0] acc, word, nword;
   logic [1:0]  ridx;
   logic [7:0]  mem [8];
   logic [2:0]  wp, rp;
   logic [3:0]  fcnt;
   logic        full, empty, pop, tx_ready;

   uart_rx #(.Prescale(Prescale)) u_rx (
      .clk(clk_i), .rst(reset_i), .rxd(rx_data_i),
      .tdata(rx_byte), .tvalid(rx_valid), .tready(rx_ready)
   );

   uart_tx #(.Prescale(Prescale)) u_tx (
      .clk(clk_i), .rst(reset_i), .tdata(mem[rp]),
      .tvalid(!empty), .tready(tx_ready), .txd(tx_data_o)
   );

   assign full     = fcnt == 4'd8;
   assign empty    = fcnt == 4'd0;
   assign pop      = tx_ready && !empty;
   assign arith    = (op == 8'hA5) || (op == 8'hB4);
   assign len_full = {rx_byte, len_lo};
   assign nword    = {rx_byte, word[31:8]};
   assign last     = (pcnt + 16'd1) == plen;
   assign rx_ready = (state != RESP) && !full;
   assign take     = rx_valid && rx_ready;

   // packet state register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state <= HDR0;
      else state <= nxt;
   end

   // next state and FIFO push source (echo byte or result byte)
   always_comb begin
      nxt       = state;
      push      = 1'b0;
      push_data = rx_byte;
      unique case (state)
         HDR0: if (take) nxt = HDR1;
         HDR1: if (take) nxt = LENL;
         LENL: if (take) nxt = LENH;
         LENH: if (take) begin
            if (len_full > 16'd4) nxt = PAYLOAD;
            else if (arith) nxt = RESP;
            else nxt = HDR0;
         end
         PAYLOAD: if (take) begin
            push = op == 8'hEC;
            if (last) nxt = arith ? RESP : HDR0;
         end
         RESP: if (!full) begin
            push      = 1'b1;
            push_data = acc[{ridx, 3'b000} +: 8];
            if (ridx == 2'd3) nxt = HDR0;
         end
         default: nxt = HDR0;
      endcase
   end

   // header capture, payload counting and word accumulation
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         op     <= '0;
         len_lo <= '0;
         plen   <= '0;
         pcnt   <= '0;
         acc    <= '0;
         word   <= '0;
         ridx   <= '0;
      end else begin
         if (take && state == HDR0) begin
            op   <= rx_byte;
            acc  <= (rx_byte == 8'hB4) ? 32'd1 : 32'd0;
            pcnt <= '0;
            word <= '0;
            ridx <= '0;
         end
         if (take && state == LENL) len_lo <= rx_byte;
         if (take && state == LENH)
            plen <= (len_full > 16'd4) ? len_full - 16'd4 : 16'd0;
         if (take && state == PAYLOAD) begin
            pcnt <= pcnt + 16'd1;
            word <= nword;
            if (pcnt[1:0] == 2'd3)
               acc <= (op == 8'hA5) ? acc + nword : acc * nword;
         end
         if (push && state == RESP) ridx <= ridx + 2'd1;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wp   <= '0;
         rp   <= '0;
         fcnt <= '0;
      end else begin
         if (push) wp <= wp + 3'd1;
         if (pop) rp <= rp + 3'd1;
         fcnt <= fcnt + {3'b000, push} - {3'b000, pop};
      end
   end

   // FIFO storage
   always_ff @(posedge clk_i) begin
      if (push) mem[wp] <= push_data;
   end
endmodule

// File: tb/tb_uart_alu_wrap.sv
// tb_uart_alu_wrap: serial-level bench for the UART packet engine.
// Vector table, hand sequences and random packets checked against a packet model.

module tb_uart_alu_wrap;
   logic clk_i = 1'b0;
   logic reset_i = 1'b1;
   logic rx_data_i = 1'b1;
   logic tx_data_o;

   uart_alu_wrap #(.Prescale(16'd1)) dut (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .rx_data_i(rx_data_i),
      .tx_data_o(tx_data_o)
   );

   always #5 clk_i = ~clk_i;

   typedef logic [7:0] bq_t [$];

   typedef struct {
      string        name;
      int           n;
      logic [127:0] pkt;
      int           ne;
      logic [63:0]  rsp;
   } vec_t;

   int passed = 0;
   int total = 0;
   int frame_err = 0;
   logic [7:0] got_q [$];
   logic [7:0] exp_q [$];
   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data_i = 1'b0;
      repeat (8) @(posedge clk_i);
      for (int i = 0; i < 8; i++) begin
         rx_data_i = b[i];
         repeat (8) @(posedge clk_i);
      end
      rx_data_i = 1'b1;
      repeat (8) @(posedge clk_i);
   endtask

   task automatic send_pkt(input bq_t p);
      foreach (p[i]) send_byte(p[i]);
   endtask

   // remote receiver: decodes tx_data_o mid-bit
   initial begin : mon
      logic [7:0] b;
      forever begin
         @(negedge tx_data_o);
         repeat (4) @(negedge clk_i);
         if (tx_data_o == 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               repeat (8) @(negedge clk_i);
               b[i] = tx_data_o;
            end
            repeat (8) @(negedge clk_i);
            if (tx_data_o === 1'b1) got_q.push_back(b);
            else frame_err++;
         end
      end
   end

   // expected reply of one packet from the command rules
   function automatic void model(input bq_t p);
      int len;
      logic [31:0] acc, w;
      exp_q.delete();
      len = int'({p[3], p[2]});
      if (len < 4) len = 4;
      case (p[0])
         8'hEC: for (int i = 4; i < len; i++) exp_q.push_back(p[i]);
         8'hA5, 8'hB4: begin
            acc = (p[0] == 8'hB4) ? 32'd1 : 32'd0;
            for (int k = 4; k + 3 < len; k += 4) begin
               w = {p[k+3], p[k+2], p[k+1], p[k]};
               if (p[0] == 8'hA5) acc = acc + w;
               else acc = acc * w;
            end
            for (int i = 0; i < 4; i++) exp_q.push_back(acc[8*i +: 8]);
         end
         default: ;
      endcase
   endfunction

   task automatic expect_resp(input string nm);
      int n;
      int waited;
      logic [31:0] a;
      n = exp_q.size();
      waited = 0;
      while (got_q.size() < n && waited < 200 * (n + 2)) begin
         @(posedge clk_i);
         waited++;
      end
      repeat (200) @(posedge clk_i);
      chk($sformatf("%s_nbytes", nm), 32'(got_q.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         a = (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF;
         chk($sformatf("%s_byte%0d", nm, i), a, {24'h0, exp_q[i]});
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic setv(input int i, input string nm, input int n,
                       input logic [127:0] pkt, input int ne, input logic [63:0] rsp);
      tbl[i].name = nm;
      tbl[i].n    = n;
      tbl[i].pkt  = pkt;
      tbl[i].ne   = ne;
      tbl[i].rsp  = rsp;
   endtask

   initial begin
      bq_t p;
      logic [7:0] op;
      int n;

      setv(0, "echo2", 6, {48'hEC0006004869, 80'h0}, 2, {16'h4869, 48'h0});
      setv(1, "add_wrap", 12, {96'hA5000C0001000000FFFFFFFF, 32'h0}, 4, 64'h0);
      setv(2, "add_empty", 4, {32'hA5000400, 96'h0}, 4, 64'h0);
      setv(3, "mul_3x5", 12, {96'hB4000C000300000005000000, 32'h0}, 4, {32'h0F000000, 32'h0});
      setv(4, "mul_empty", 4, {32'hB4000400, 96'h0}, 4, {32'h01000000, 32'h0});
      setv(5, "drop_op", 6, {48'h77000600AABB, 80'h0}, 0, 64'h0);
      setv(6, "echo1", 5, {40'hEC0005005A, 88'h0}, 1, {8'h5A, 56'h0});
      setv(7, "add_trail", 9, {72'hA50009001020304077, 56'h0}, 4, {32'h10203040, 32'h0});

      repeat (2) @(posedge clk_i);
      #1 chk("reset_tx_idle", {31'h0, tx_data_o}, 32'd1);
      reset_i = 1'b0;
      repeat (4) @(posedge clk_i);

      // first echo byte must be out before the second byte's stop bit ends
      p = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48, 8'h69};
      send_pkt(p);
      chk("echo_latency", 32'(got_q.size() >= 1), 32'd1);
      exp_q = '{8'h48, 8'h69};
      expect_resp("echo_first");

      // 20 bit-times idle inside the payload keeps packet state
      p = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48};
      send_pkt(p);
      repeat (160) @(posedge clk_i);
      send_byte(8'h69);
      exp_q = '{8'h48, 8'h69};
      expect_resp("echo_gap");

      foreach (tbl[v]) begin
         p.delete();
         for (int i = 0; i < tbl[v].n; i++) p.push_back(tbl[v].pkt[127-8*i -: 8]);
         send_pkt(p);
         exp_q.delete();
         for (int i = 0; i < tbl[v].ne; i++) exp_q.push_back(tbl[v].rsp[63-8*i -: 8]);
         expect_resp(tbl[v].name);
      end

      // reset in the middle of a header discards that packet
      p = '{8'hEC, 8'h00, 8'h06};
      send_pkt(p);
      reset_i = 1'b1;
      repeat (2) @(negedge clk_i);
      chk("midreset_tx_idle", {31'h0, tx_data_o}, 32'd1);
      reset_i = 1'b0;
      repeat (4) @(posedge clk_i);
      p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h33};
      send_pkt(p);
      exp_q = '{8'h33};
      expect_resp("after_reset");

      for (int r = 0; r < 12; r++) begin
         case ($urandom_range(0, 3))
            0: op = 8'hEC;
            1: op = 8'hA5;
            2: op = 8'hB4;
            default: begin
               op = 8'($urandom_range(0, 255));
               if (op == 8'hEC || op == 8'hA5 || op == 8'hB4) op = 8'h11;
            end
         endcase
         n = $urandom_range(0, 10);
         p.delete();
         p.push_back(op);
         p.push_back(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 4) == 0) begin
            n = 0;
            p.push_back(8'($urandom_range(0, 3)));
         end else begin
            p.push_back(8'(n + 4));
         end
         p.push_back(8'h00);
         for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
         model(p);
         send_pkt(p);
         expect_resp($sformatf("rand%0d_op%02h", r, op));
      end

      chk("frame_errors", 32'(frame_err), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
